// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue issue/writeback stage wrapped around an 8-bit ALU.
// Owns an 8x8 register file and the architectural carry/zero/sign flags.
`default_nettype none

module alu_sequencer #(
  parameter int NREGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr_op,
  input  logic [2:0] instr_rd,
  input  logic [2:0] instr_rs,
  input  logic [7:0] instr_imm,
  input  logic       instr_use_imm,
  output logic       alu_enable,
  output logic [7:0] alu_operation,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_cpu_carry,
  input  logic [7:0] alu_result_l,
  input  logic [7:0] alu_result_h,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic       wb_valid,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_s,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] regs [NREGS];
  logic [7:0] op_q;
  logic [7:0] imm_q;
  logic [2:0] rd_q;
  logic [2:0] rs_q;
  logic       use_imm_q;
  logic       c_q;
  logic       z_q;
  logic       s_q;

  logic       accept;
  logic       is_mul;
  logic       is_flag_only;
  logic [2:0] rd_hi;

  // MUL occupies two opcode pairs; SETC/CLRC only touch the flags.
  assign is_mul       = op_q[7] && ((op_q[6:1] == 6'b001000) || (op_q[6:1] == 6'b001001));
  assign is_flag_only = (op_q == 8'h04) || (op_q == 8'h05);
  assign rd_hi        = rd_q + 3'd1;
  assign accept       = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= 8'h00;
      imm_q     <= 8'h00;
      rd_q      <= 3'd0;
      rs_q      <= 3'd0;
      use_imm_q <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      s_q       <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      state <= state_next;
      if (accept) begin
        op_q      <= instr_op;
        imm_q     <= instr_imm;
        rd_q      <= instr_rd;
        rs_q      <= instr_rs;
        use_imm_q <= instr_use_imm;
      end
      if (state == WRITE) begin
        c_q <= alu_carry;
        z_q <= alu_zero;
        s_q <= alu_sign;
        if (!is_flag_only) begin
          regs[rd_q] <= alu_result_l;
        end
        // High byte lands in the next register, wrapping rd=7 onto reg0.
        if (is_mul) begin
          regs[rd_hi] <= alu_result_h;
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    alu_enable  = 1'b0;
    wb_valid    = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        alu_enable = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        wb_valid   = !is_flag_only;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign alu_operation = op_q;
  assign alu_op1       = regs[rd_q];
  assign alu_op2       = use_imm_q ? imm_q : regs[rs_q];
  assign alu_cpu_carry = c_q;

  assign wb_addr  = wb_valid ? rd_q : 3'd0;
  assign wb_data  = wb_valid ? alu_result_l : 8'h00;

  assign flag_c   = c_q;
  assign flag_z   = z_q;
  assign flag_s   = s_q;

  assign dbg_data = regs[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: an ALU stand-in, an architectural model and directed instructions.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr_op = 8'h00;
  logic [2:0] instr_rd = 3'd0;
  logic [2:0] instr_rs = 3'd0;
  logic [7:0] instr_imm = 8'h00;
  logic       instr_use_imm = 1'b0;
  logic       alu_enable;
  logic [7:0] alu_operation, alu_op1, alu_op2;
  logic       alu_cpu_carry;
  logic [7:0] alu_result_l = 8'h00, alu_result_h = 8'h00;
  logic       alu_carry = 1'b0, alu_zero = 1'b0, alu_sign = 1'b0;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       flag_c, flag_z, flag_s;
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;

  int n_chk = 0;
  int n_fail = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_imm(instr_imm), .instr_use_imm(instr_use_imm),
    .alu_enable(alu_enable), .alu_operation(alu_operation),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cpu_carry(alu_cpu_carry),
    .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Returns {result_h, result_l, carry, zero, sign}
  function automatic logic [18:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    logic [15:0] p;
    logic [8:0]  t;
    logic [7:0]  l, h;
    logic        c, z;
    p = 16'h0; t = 9'h0; h = 8'h00; l = 8'h00; c = 1'b0;
    if (op[7] && op[6:2] == 5'b00100) begin
      p = {8'h00, a} * {8'h00, b};
      l = p[7:0]; h = p[15:8]; c = (h != 8'h00);
    end else begin
      case (op)
        8'h02: begin t = {1'b0, a} + 9'd1; l = t[7:0]; c = t[8]; end
        8'h04: begin l = a; c = 1'b1; end
        8'h05: begin l = a; c = 1'b0; end
        8'h88: begin t = {1'b0, a} + {1'b0, b} + {8'h00, cin}; l = t[7:0]; c = t[8]; end
        8'h8C: begin t = {1'b0, a} - {1'b0, b}; l = t[7:0]; c = t[8]; end
        default: begin l = a ^ b; c = 1'b0; end
      endcase
    end
    z = ({h, l} == 16'h0000);
    return {h, l, c, z, l[7]};
  endfunction

  function automatic bit is_mul(input logic [7:0] op);
    return op[7] && (op[6:1] == 6'b001000 || op[6:1] == 6'b001001);
  endfunction

  function automatic bit is_flag_only(input logic [7:0] op);
    return op == 8'h04 || op == 8'h05;
  endfunction

  // ALU stand-in: registers its outputs on the edge that ends an enabled cycle
  always @(posedge clk) begin
    if (alu_enable) begin
      {alu_result_h, alu_result_l, alu_carry, alu_zero, alu_sign} <=
        alu_fn(alu_operation, alu_op1, alu_op2, alu_cpu_carry);
    end
  end

  // Architectural model: age = edges since acceptance, -1 when no instruction is in flight
  int         age = -1;
  logic [7:0] m_reg [8];
  logic       m_c = 1'b0, m_z = 1'b0, m_s = 1'b0;
  logic [7:0] t_op = 8'h00, t_imm = 8'h00;
  logic [2:0] t_rd = 3'd0, t_rs = 3'd0;
  logic       t_use = 1'b0;

  function automatic logic [18:0] model_result();
    return alu_fn(t_op, m_reg[t_rd], t_use ? t_imm : m_reg[t_rs], m_c);
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [18:0] r;
    logic [2:0]  hi;
    if (!rst) begin
      age = -1;
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      {m_c, m_z, m_s} = 3'b000;
      t_op = 8'h00; t_imm = 8'h00; t_rd = 3'd0; t_rs = 3'd0; t_use = 1'b0;
    end else if (age == 1) begin
      r  = model_result();
      hi = t_rd + 3'd1;
      if (!is_flag_only(t_op)) m_reg[t_rd] = r[10:3];
      if (is_mul(t_op)) m_reg[hi] = r[18:11];
      {m_c, m_z, m_s} = r[2:0];
      age = -1;
    end else if (age == 0) begin
      age = 1;
    end else if (instr_valid) begin
      t_op = instr_op; t_imm = instr_imm; t_rd = instr_rd; t_rs = instr_rs; t_use = instr_use_imm;
      age = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle out of reset, DUT against the model
  always @(negedge clk) begin
    logic [18:0] r;
    if (rst) begin
      r = model_result();
      chk("instr_ready", instr_ready, age < 0);
      chk("alu_enable", alu_enable, age == 0);
      chk("alu_operation", alu_operation, t_op);
      chk("alu_op1", alu_op1, m_reg[t_rd]);
      chk("alu_op2", alu_op2, t_use ? t_imm : m_reg[t_rs]);
      chk("alu_cpu_carry", alu_cpu_carry, m_c);
      chk("wb_valid", wb_valid, (age == 1) && !is_flag_only(t_op));
      if (age == 1 && !is_flag_only(t_op)) begin
        chk("wb_addr", wb_addr, t_rd);
        chk("wb_data", wb_data, r[10:3]);
      end
      chk("flags", {flag_c, flag_z, flag_s}, {m_c, m_z, m_s});
      chk("dbg_data", dbg_data, m_reg[dbg_addr]);
    end
  end

  task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [7:0] imm, input logic use_imm,
                       output int wb_lat, output int rdy_lat, output logic [2:0] wa,
                       output logic [7:0] wd, output logic cin);
    bit got;
    got = 0; wb_lat = -1; rdy_lat = -1; wa = 3'd0; wd = 8'h00; cin = 1'b0;
    @(negedge clk);
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_imm = imm; instr_use_imm = use_imm;
    instr_valid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      if (instr_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL handshake_timeout: instr_ready got 0 expected 1");
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int i = 1; i <= 6 && rdy_lat < 0; i++) begin
      @(negedge clk);
      if (alu_enable) cin = alu_cpu_carry;
      if (wb_valid && wb_lat < 0) begin wb_lat = i; wa = wb_addr; wd = wb_data; end
      if (instr_ready) rdy_lat = i;
    end
    if (rdy_lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: instr_ready got 0 expected 1");
    end
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [7:0] exp);
    @(posedge clk);
    #1 dbg_addr = a;
    #1 chk(name, dbg_data, exp);
  endtask

  initial begin
    int wl, rl;
    logic [2:0] wa;
    logic [7:0] wd;
    logic cin;

    repeat (3) @(negedge clk);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_alu_enable", alu_enable, 1'b0);
    chk("rst_wb_addr_data", {wb_addr, wb_data}, 11'h000);
    chk("rst_alu_side", {alu_operation, alu_op1, alu_op2, alu_cpu_carry}, 25'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_flags", {flag_c, flag_z, flag_s}, 3'b000);

    // INC r1
    issue(8'h02, 3'd1, 3'd0, 8'h00, 1'b0, wl, rl, wa, wd, cin);
    chk("inc_wb_latency", wl, 2);
    chk("inc_ready_latency", rl, 3);
    chk("inc_wb_addr", wa, 3'd1);
    chk("inc_wb_data", wd, 8'h01);
    chk("inc_flags", {flag_c, flag_z, flag_s}, 3'b000);
    peek("inc_r1", 3'd1, 8'h01);

    // r2 = 1, then ADD r2 + 0xFF -> 0 with carry, then ADD r3 + 0 + carry
    issue(8'h02, 3'd2, 3'd0, 8'h00, 1'b0, wl, rl, wa, wd, cin);
    issue(8'h88, 3'd2, 3'd0, 8'hFF, 1'b1, wl, rl, wa, wd, cin);
    chk("addi_carry_out", flag_c, 1'b1);
    peek("addi_r2", 3'd2, 8'h00);
    issue(8'h88, 3'd3, 3'd0, 8'h00, 1'b1, wl, rl, wa, wd, cin);
    chk("addc_carry_in", cin, 1'b1);
    peek("addc_r3", 3'd3, 8'h01);

    // MUL r7 * r6 with rd=7 wrapping the high byte into r0
    issue(8'h88, 3'd7, 3'd0, 8'h10, 1'b1, wl, rl, wa, wd, cin);
    issue(8'h88, 3'd6, 3'd0, 8'h20, 1'b1, wl, rl, wa, wd, cin);
    issue(8'h90, 3'd7, 3'd6, 8'h00, 1'b0, wl, rl, wa, wd, cin);
    chk("mul_wb_addr", wa, 3'd7);
    chk("mul_wb_data", wd, 8'h00);
    peek("mul_r7", 3'd7, 8'h00);
    peek("mul_r0", 3'd0, 8'h02);

    // SETC / CLRC: flags only
    issue(8'h04, 3'd0, 3'd0, 8'h00, 1'b0, wl, rl, wa, wd, cin);
    chk("setc_no_wb", wl, -1);
    chk("setc_flag_c", flag_c, 1'b1);
    peek("setc_r0", 3'd0, 8'h02);
    peek("setc_r1", 3'd1, 8'h01);
    issue(8'h05, 3'd0, 3'd0, 8'h00, 1'b0, wl, rl, wa, wd, cin);
    chk("clrc_no_wb", wl, -1);
    chk("clrc_flag_c", flag_c, 1'b0);

    // SUB r4 - r5 with equal values
    issue(8'h88, 3'd4, 3'd0, 8'h05, 1'b1, wl, rl, wa, wd, cin);
    issue(8'h88, 3'd5, 3'd0, 8'h05, 1'b1, wl, rl, wa, wd, cin);
    issue(8'h8C, 3'd4, 3'd5, 8'h00, 1'b0, wl, rl, wa, wd, cin);
    chk("sub_flag_z", flag_z, 1'b1);
    peek("sub_r4", 3'd4, 8'h00);

    // instr_valid held high: three INC r5 accepted one every 3 cycles
    @(negedge clk);
    instr_op = 8'h02; instr_rd = 3'd5; instr_use_imm = 1'b0; instr_valid = 1'b1;
    repeat (7) @(negedge clk);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    peek("held_valid_r5", 3'd5, 8'h08);

    // Undecoded opcode still writes result_l back
    issue(8'h3F, 3'd1, 3'd0, 8'h0F, 1'b1, wl, rl, wa, wd, cin);
    chk("undecoded_wb_data", wd, 8'h0E);
    peek("undecoded_r1", 3'd1, 8'h0E);

    // Reset during WRITE of ADD r3
    @(negedge clk);
    instr_op = 8'h88; instr_rd = 3'd3; instr_imm = 8'h03; instr_use_imm = 1'b1; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rstw_wb_valid", wb_valid, 1'b0);
    chk("rstw_wb_data", wb_data, 8'h00);
    @(negedge clk);
    chk("rstw_alu_enable", alu_enable, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ready", instr_ready, 1'b1);
    chk("rstw_flags", {flag_c, flag_z, flag_s}, 3'b000);
    peek("rstw_r3", 3'd3, 8'h00);
    peek("rstw_r1", 3'd1, 8'h00);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
